rsa_core_arbiter: RTL and testbench
===================================

Name: rsa_core_arbiter

Overview:
- Shares one Rsa256Core between two independent requesters, e.g. two Avalon UART wrapper channels.
- Arbitrates round-robin, latches the winner's operands (a, d, n) and pulses the core start.
- Waits for core completion, then returns the result to the owning requester with a one-cycle done pulse.
- Also reports the cycle latency of the last operation for performance profiling.

Parameters:
- RSA_W, 256, operand/result width in bits.
- CNT_W, 32, width of the latency counter.

Ports:
- avm_clk  in  1  system clock; all logic on the rising edge.
- avm_rst  in  1  reset, synchronous, active-high.
- i_valid  in  2  bit k = requester k has an operation pending.
- o_ready  out  2  bit k = requester k accepted this cycle (accept = i_valid[k] && o_ready[k]).
- i_a  in  2*RSA_W  ciphertext; requester k at [RSA_W*k +: RSA_W].
- i_d  in  2*RSA_W  private exponent, same packing.
- i_n  in  2*RSA_W  modulus, same packing.
- o_result  out  RSA_W  last completed a^d mod n; registered.
- o_done  out  2  one-cycle pulse to the owning requester; o_result valid that cycle.
- o_cycles  out  CNT_W  latency of the last completed operation, in cycles; registered.
- o_busy  out  1  high whenever state != S_IDLE.
- core_start  out  1  to Rsa256Core i_start; registered one-cycle pulse.
- core_a / core_d / core_n  out  RSA_W each  registered operands to the core; stable from core_start until completion.
- core_result  in  RSA_W  from Rsa256Core o_a_pow_d.
- core_finished  in  1  from Rsa256Core o_finished.

Behaviour:
- Reset (synchronous, avm_rst=1 at an edge):
  - State → S_IDLE; last_grant → 1, so requester 0 wins first.
  - Outputs and registers cleared: o_result=0, o_cycles=0, o_done=0, core_start=0, core_a/d/n=0, owner=0.
  - Mid-operation reset aborts the operation with no o_done; the core is on the same reset.
- Arbitration, combinational, S_IDLE only:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - o_ready[grant]=1 when at least one is valid; o_ready=0 in all other states.
  - o_ready may depend on i_valid; requesters must not make i_valid depend on o_ready.
- States:
  - S_IDLE:
    - On accept: latch core_a/d/n from the granted slice, owner=grant, last_grant=grant, cnt=0, set core_start=1 → S_START.
    - A requester may drop i_valid before acceptance with no effect.
  - S_START:
    - core_start is high this cycle only; cnt=1 → S_BUSY.
    - core_finished is ignored in this cycle (it may be stale from the previous run).
  - S_BUSY:
    - cnt increments, saturating at all-ones.
    - On core_finished: o_result<=core_result, o_cycles<=cnt+1 (saturating), o_done[owner]<=1 → S_DONE.
  - S_DONE: o_done pulses this cycle → S_IDLE.
- Latency:
  - Accept at edge T; core_start high in cycle T+1.
  - core_finished sampled in cycle F gives o_done and o_result in cycle F+1.
  - Next accept is possible at edge F+2.
- o_result and o_cycles hold until the next completion.
- core_finished in S_IDLE or S_DONE is ignored.
- Non-granted i_valid stays pending; no starvation is guaranteed under continuous contention (strict alternation).
- Width rules:
  - core_cycles counter saturates, never wraps.
  - Operands pass through unmodified; requesters guarantee a < n.

Decomposition:
- Package rsa_pkg holds:
  - RSA_W and the requester-count constant (2).
  - Enum arb_state_t {S_IDLE, S_START, S_BUSY, S_DONE}.
  - Slice helper localparams.
- Sub-module rr_arb2: combinational 2-way round-robin pick.
  - Inputs: valid[1:0], last[0].
  - Outputs: grant index, any_valid.
  - Reusable for a future TX-channel mux.

Test Plan:
- Single request, real core: requester 0 with a=4, d=13, n=497 → one core_start pulse; o_done=2'b01 and o_result=445; o_busy low after S_DONE.
- Stub core with fixed finished 5 cycles after start: accept at edge T → core_start in cycle T+1, o_done in cycle T+7, o_cycles=6.
- Both valid every cycle from reset:
  - Grant order 0,1,0,1.
  - Requester 1 uses a=2, d=10, n=1000 → o_result=24 with o_done=2'b10.
  - Operands are never mixed between requesters.
- Stale core_finished held high through S_IDLE and the start cycle → no early o_done; completion only on the S_BUSY sample.
- avm_rst asserted in S_BUSY:
  - Next cycle: state idle, o_busy=0, o_done never pulses.
  - A new request from requester 0 is accepted first.
- Counter saturation: CNT_W=3, stub latency 20 cycles → o_cycles=7.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA core arbiter slice.
package rsa_pkg;

  localparam int RSA_W     = 256;
  localparam int NUM_REQ   = 2;
  localparam int REQ_IDX_W = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to whoever did not win last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any_valid
);

  always_comb begin
    any_valid = |valid;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/rsa_core_arbiter.sv
// Shares one Rsa256Core between two requesters: round-robin accept, launch, wait, return
// the result to the owner and record the operation latency.
module rsa_core_arbiter #(
  parameter int RSA_W = 256,
  parameter int CNT_W = 32
) (
  input  logic               avm_clk,
  input  logic               avm_rst,
  input  logic [1:0]         i_valid,
  output logic [1:0]         o_ready,
  input  logic [2*RSA_W-1:0] i_a,
  input  logic [2*RSA_W-1:0] i_d,
  input  logic [2*RSA_W-1:0] i_n,
  output logic [RSA_W-1:0]   o_result,
  output logic [1:0]         o_done,
  output logic [CNT_W-1:0]   o_cycles,
  output logic               o_busy,
  output logic               core_start,
  output logic [RSA_W-1:0]   core_a,
  output logic [RSA_W-1:0]   core_d,
  output logic [RSA_W-1:0]   core_n,
  input  logic [RSA_W-1:0]   core_result,
  input  logic               core_finished
);

  import rsa_pkg::*;

  arb_state_t         state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [RSA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [1:0]         done_q, done_d;
  logic               start_q, start_d;
  logic [RSA_W-1:0]   core_a_q, core_a_d;
  logic [RSA_W-1:0]   core_d_q, core_d_d;
  logic [RSA_W-1:0]   core_n_q, core_n_d;

  logic               grant;
  logic               any_valid;
  logic [RSA_W-1:0]   sel_a, sel_d, sel_n;

  rr_arb2 u_arb (
    .valid     (i_valid),
    .last      (last_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign sel_a = grant ? i_a[RSA_W +: RSA_W] : i_a[0 +: RSA_W];
  assign sel_d = grant ? i_d[RSA_W +: RSA_W] : i_d[0 +: RSA_W];
  assign sel_n = grant ? i_n[RSA_W +: RSA_W] : i_n[0 +: RSA_W];

  always_comb begin
    o_ready = 2'b00;
    if (state_q == S_IDLE && any_valid) begin
      o_ready = 2'b01 << grant;
    end
  end

  // core_finished is only trusted in S_BUSY; in S_START it may still be high from the last run.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cycles_d = cycles_q;
    done_d   = 2'b00;
    start_d  = 1'b0;
    core_a_d = core_a_q;
    core_d_d = core_d_q;
    core_n_d = core_n_q;
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          core_a_d = sel_a;
          core_d_d = sel_d;
          core_n_d = sel_n;
          owner_d  = grant;
          last_d   = grant;
          cnt_d    = '0;
          start_d  = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d   = CNT_W'(1);
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (core_finished) begin
          result_d        = core_result;
          cycles_d        = cnt_inc;
          done_d[owner_q] = 1'b1;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cycles_q <= '0;
      done_q   <= 2'b00;
      start_q  <= 1'b0;
      core_a_q <= '0;
      core_d_q <= '0;
      core_n_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
      start_q  <= start_d;
      core_a_q <= core_a_d;
      core_d_q <= core_d_d;
      core_n_q <= core_n_d;
    end
  end

  assign o_result   = result_q;
  assign o_cycles   = cycles_q;
  assign o_done     = done_q;
  assign o_busy     = (state_q != S_IDLE);
  assign core_start = start_q;
  assign core_a     = core_a_q;
  assign core_d     = core_d_q;
  assign core_n     = core_n_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Randomized bench for rsa_core_arbiter: behavioural core stubs plus a transaction-level
// timing/result model; a second instance with a 3-bit counter covers saturation.
module tb_rsa_core_arbiter;

  localparam int RSA_W = 256;
  localparam int CNT_W = 32;
  localparam int SAT_W = 3;

  logic avm_clk = 1'b0;
  logic avm_rst;
  always #5 avm_clk = ~avm_clk;

  // Main instance
  logic [1:0]         i_valid, o_ready, o_done;
  logic [2*RSA_W-1:0] i_a, i_d, i_n;
  logic [RSA_W-1:0]   o_result, core_a, core_d, core_n, core_result;
  logic [CNT_W-1:0]   o_cycles;
  logic               o_busy, core_start, core_finished;

  // Saturation instance
  logic [1:0]         s_valid, s_ready, s_done;
  logic [2*RSA_W-1:0] s_a, s_d, s_n;
  logic [RSA_W-1:0]   s_result, s_core_a, s_core_d, s_core_n, s_core_result;
  logic [SAT_W-1:0]   s_cycles;
  logic               s_busy, s_core_start, s_core_finished;

  rsa_core_arbiter #(.RSA_W(RSA_W), .CNT_W(CNT_W)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_d(i_d), .i_n(i_n), .o_result(o_result), .o_done(o_done),
    .o_cycles(o_cycles), .o_busy(o_busy), .core_start(core_start),
    .core_a(core_a), .core_d(core_d), .core_n(core_n),
    .core_result(core_result), .core_finished(core_finished)
  );

  rsa_core_arbiter #(.RSA_W(RSA_W), .CNT_W(SAT_W)) dut_sat (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .i_valid(s_valid), .o_ready(s_ready),
    .i_a(s_a), .i_d(s_d), .i_n(s_n), .o_result(s_result), .o_done(s_done),
    .o_cycles(s_cycles), .o_busy(s_busy), .core_start(s_core_start),
    .core_a(s_core_a), .core_d(s_core_d), .core_n(s_core_n),
    .core_result(s_core_result), .core_finished(s_core_finished)
  );

  function automatic logic [63:0] modexp(input logic [63:0] a, input logic [63:0] d,
                                         input logic [63:0] n);
    logic [63:0] r, b;
    if (n == 0) return 64'd0;
    r = 64'd1 % n;
    b = a % n;
    for (int i = 0; i < 64; i++) begin
      if (d[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  // Behavioural core stub: finishes 'lat' cycles after start; in stale mode finished stays high
  // until the next start.
  logic [7:0]  lat;
  logic        stale_mode;
  logic [7:0]  st_rem;
  logic        st_hold;
  logic [63:0] st_res;

  always @(posedge avm_clk) begin
    if (avm_rst) begin
      st_rem  <= 8'd0;
      st_hold <= 1'b0;
      st_res  <= 64'd0;
    end else if (core_start) begin
      st_rem  <= lat;
      st_hold <= 1'b0;
      st_res  <= modexp(core_a[63:0], core_d[63:0], core_n[63:0]);
    end else begin
      if (st_rem != 8'd0) st_rem <= st_rem - 8'd1;
      if (st_rem == 8'd1 && stale_mode) st_hold <= 1'b1;
    end
  end
  assign core_finished = (st_rem == 8'd1) || st_hold;
  assign core_result   = {{(RSA_W-64){1'b0}}, st_res};

  logic [7:0]  s_rem;
  logic [63:0] s_res;
  always @(posedge avm_clk) begin
    if (avm_rst) begin
      s_rem <= 8'd0;
      s_res <= 64'd0;
    end else if (s_core_start) begin
      s_rem <= 8'd20;
      s_res <= modexp(s_core_a[63:0], s_core_d[63:0], s_core_n[63:0]);
    end else if (s_rem != 8'd0) begin
      s_rem <= s_rem - 8'd1;
    end
  end
  assign s_core_finished = (s_rem == 8'd1);
  assign s_core_result   = {{(RSA_W-64){1'b0}}, s_res};

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [RSA_W-1:0] act,
                             input logic [RSA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Transaction-level model: one operation in flight, known accept and completion cycles.
  int               cyc;
  bit               m_active;
  int               m_acc, m_done;
  logic             m_owner, m_last;
  logic [RSA_W-1:0] m_result, m_exp_res, m_a, m_d, m_n;
  logic [CNT_W-1:0] m_cycles, m_exp_cyc;

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = 1'b1;
    m_result = '0;
    m_cycles = '0;
  endtask

  task automatic do_reset();
    @(posedge avm_clk);
    #1;
    avm_rst = 1'b1;
    i_valid = 2'b00;
    model_reset();
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [63:0] a0, input logic [63:0] d0, input logic [63:0] n0,
                               input logic [63:0] a1, input logic [63:0] d1, input logic [63:0] n1,
                               output int acc);
    logic [1:0] exp_ready, exp_done;
    logic       exp_start;
    int         g;
    longint     lsat, cmax;
    @(posedge avm_clk);
    #1;
    avm_rst = 1'b0;
    i_valid = v;
    i_a = {RSA_W'(a1), RSA_W'(a0)};
    i_d = {RSA_W'(d1), RSA_W'(d0)};
    i_n = {RSA_W'(n1), RSA_W'(n0)};
    #1;
    cyc++;
    if (m_active && cyc == m_done) begin
      m_result = m_exp_res;
      m_cycles = m_exp_cyc;
    end
    g = -1;
    acc = -1;
    exp_ready = 2'b00;
    if (!m_active && v != 2'b00) begin
      if (v == 2'b11) g = m_last ? 0 : 1;
      else g = v[1] ? 1 : 0;
      exp_ready = 2'b01 << g;
    end
    exp_done  = (m_active && cyc == m_done) ? (2'b01 << m_owner) : 2'b00;
    exp_start = m_active && (cyc == m_acc + 1);
    checkOutput("o_ready", RSA_W'(o_ready), RSA_W'(exp_ready));
    checkOutput("o_done", RSA_W'(o_done), RSA_W'(exp_done));
    checkOutput("o_busy", RSA_W'(o_busy), RSA_W'(m_active));
    checkOutput("core_start", RSA_W'(core_start), RSA_W'(exp_start));
    checkOutput("o_result", o_result, m_result);
    checkOutput("o_cycles", RSA_W'(o_cycles), RSA_W'(m_cycles));
    if (exp_start) begin
      checkOutput("core_a", core_a, m_a);
      checkOutput("core_d", core_d, m_d);
      checkOutput("core_n", core_n, m_n);
    end
    if (m_active && cyc == m_done) m_active = 1'b0;
    if (g >= 0) begin
      acc      = g;
      m_active = 1'b1;
      m_acc    = cyc;
      m_done   = cyc + int'(lat) + 2;
      m_owner  = g[0];
      m_last   = g[0];
      m_a = (g == 1) ? RSA_W'(a1) : RSA_W'(a0);
      m_d = (g == 1) ? RSA_W'(d1) : RSA_W'(d0);
      m_n = (g == 1) ? RSA_W'(n1) : RSA_W'(n0);
      m_exp_res = RSA_W'(modexp(m_a[63:0], m_d[63:0], m_n[63:0]));
      cmax = (longint'(1) << CNT_W) - 1;
      lsat = longint'(lat) + 1;
      if (lsat > cmax) lsat = cmax;
      m_exp_cyc = CNT_W'(lsat);
    end
  endtask

  initial begin
    int          acc;
    int          waited;
    logic [1:0]  pend;
    logic [63:0] ra [2];
    logic [63:0] rd [2];
    logic [63:0] rn [2];

    avm_rst    = 1'b1;
    i_valid    = 2'b00;
    i_a        = '0;
    i_d        = '0;
    i_n        = '0;
    s_valid    = 2'b00;
    s_a        = {RSA_W'(64'd0), RSA_W'(64'd5)};
    s_d        = {RSA_W'(64'd0), RSA_W'(64'd3)};
    s_n        = {RSA_W'(64'd1), RSA_W'(64'd13)};
    lat        = 8'd5;
    stale_mode = 1'b0;
    cyc        = 0;
    pend       = 2'b00;
    model_reset();

    $display("[TB] reset and single request");
    do_reset();
    applyStimulus(2'b00, 0, 0, 1, 0, 0, 1, acc);
    checkOutput("rst_core_a", core_a, '0);
    checkOutput("rst_core_d", core_d, '0);
    checkOutput("rst_core_n", core_n, '0);

    lat = 8'd5;
    applyStimulus(2'b01, 64'd4, 64'd13, 64'd497, 0, 0, 1, acc);
    for (int i = 0; i < 12; i++) applyStimulus(2'b00, 0, 0, 1, 0, 0, 1, acc);

    $display("[TB] continuous contention from reset");
    do_reset();
    lat = 8'd3;
    for (int i = 0; i < 40; i++)
      applyStimulus(2'b11, 64'd3, 64'd5, 64'd77, 64'd2, 64'd10, 64'd1000, acc);

    $display("[TB] stale core_finished");
    stale_mode = 1'b1;
    lat = 8'd4;
    for (int i = 0; i < 36; i++)
      applyStimulus((i % 12 < 2) ? 2'b01 : 2'b00, 64'd7, 64'd9, 64'd101, 0, 0, 1, acc);
    stale_mode = 1'b0;

    $display("[TB] reset during busy");
    lat = 8'd8;
    applyStimulus(2'b10, 0, 0, 1, 64'd11, 64'd17, 64'd323, acc);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 0, 0, 1, 0, 0, 1, acc);
    do_reset();
    for (int i = 0; i < 15; i++)
      applyStimulus(2'b11, 64'd6, 64'd7, 64'd55, 64'd8, 64'd3, 64'd91, acc);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if (!m_active) begin
        lat        = 8'($urandom_range(1, 8));
        stale_mode = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          rn[k]   = 64'($urandom_range(2, 65535));
          ra[k]   = 64'($urandom) % rn[k];
          rd[k]   = 64'($urandom_range(0, 65535));
        end else if (pend[k] && $urandom_range(0, 15) == 0) begin
          pend[k] = 1'b0;
        end
      end
      applyStimulus(pend, ra[0], rd[0], rn[0], ra[1], rd[1], rn[1], acc);
      if (acc >= 0) pend[acc] = 1'b0;
    end
    for (int i = 0; i < 20; i++) applyStimulus(2'b00, 0, 0, 1, 0, 0, 1, acc);

    $display("[TB] counter saturation");
    @(posedge avm_clk);
    #1;
    s_valid = 2'b01;
    #1;
    checkOutput("sat_ready", RSA_W'(s_ready), RSA_W'(2'b01));
    @(posedge avm_clk);
    #1;
    s_valid = 2'b00;
    waited = 1;
    while (s_done == 2'b00 && waited < 40) begin
      @(posedge avm_clk);
      #1;
      waited++;
    end
    checkOutput("sat_latency", RSA_W'(waited), RSA_W'(22));
    checkOutput("sat_done", RSA_W'(s_done), RSA_W'(2'b01));
    checkOutput("sat_cycles", RSA_W'(s_cycles), RSA_W'(7));
    checkOutput("sat_result", s_result, RSA_W'(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
